// File: rtl/apb_pkg.sv
// ============================================================================
// apb_pkg: shared APB bus widths, requester state encoding and command struct.
// Revision: 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ============================================================================
// apb_master_bridge: command/response port to APB requester, one transfer per
// command, with a bounded wait-state timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int C_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? C_CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  apb_state_e          state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_slverr_q, rsp_slverr_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [C_CNT_W-1:0]  cnt_q, cnt_d;

  logic w_in_access;
  logic w_timeout_hit;
  logic w_done;
  logic w_accept;

  assign w_in_access   = (state_q == ACCESS);
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == C_CNT_LAST) && !pready;
  // pready only counts in ACCESS; a ready slave during IDLE/SETUP is ignored
  assign w_done        = w_in_access && (pready || w_timeout_hit);
  assign w_accept      = cmd_valid && cmd_ready;

  // State register
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (w_done) state_d = cmd_valid ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cmd_ready     = (state_q == IDLE) || w_done;
    psel_d        = (state_d != IDLE);
    penable_d     = (state_d == ACCESS);
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = w_done;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    if (w_accept) begin
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
    end

    if (w_done) begin
      rsp_rdata_d   = (!pwrite_q && pready) ? prdata : '0;
      rsp_slverr_d  = pready ? pslverr : 1'b1;
      rsp_timeout_d = !pready;
    end

    // Counter saturates rather than wrapping so a disabled timeout never aliases
    if (w_done || (state_d == SETUP)) begin
      cnt_d = '0;
    end else if (w_in_access && !pready && (cnt_q != {C_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ============================================================================
// tb_apb_master_bridge: directed stimulus with a response scoreboard and a
// small APB slave model (memory, wait states, error address, hang).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        prst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_slverr, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [7:0]  pwdata, prdata;
  logic        pready, pslverr;

  typedef struct packed {
    logic [7:0] rdata;
    logic       slverr;
    logic       timeout;
  } rsp_t;

  rsp_t       exp_q[$];
  rsp_t       mon_e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         rsp_count = 0;
  int         cyc = 0;
  logic [7:0] mem[256];
  bit         force_rdy = 1'b0;
  bit         hang = 1'b0;
  bit         psel_watch = 1'b0;
  bit         psel_dropped = 1'b0;
  int         ws = 0;
  int         acc_cyc = 0;

  apb_master_bridge #(
    .ADDR_W(32), .DATA_W(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  // Slave model
  assign pready  = force_rdy | (psel & penable & !hang & (acc_cyc >= ws));
  assign prdata  = (psel && !pwrite) ? mem[paddr[7:0]] : 8'h00;
  assign pslverr = psel & penable & (paddr == 32'h0000_00FF);

  always @(posedge pclk) begin
    if (psel && penable) begin
      if (pready) begin
        acc_cyc <= 0;
        if (pwrite) mem[paddr[7:0]] <= pwdata;
      end else begin
        acc_cyc <= acc_cyc + 1;
      end
    end else begin
      acc_cyc <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t mk(input logic [7:0] d, input logic s, input logic t);
    rsp_t r;
    r.rdata = d; r.slverr = s; r.timeout = t;
    return r;
  endfunction

  // Scoreboard monitor
  always @(negedge pclk) begin
    if (prst && rsp_valid) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got rdata 0x%0h with no response expected", rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata",   32'(rsp_rdata),   32'(mon_e.rdata));
        chk("rsp_slverr",  32'(rsp_slverr),  32'(mon_e.slverr));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.timeout));
      end
    end
  end

  always @(negedge pclk) if (psel_watch && !psel) psel_dropped = 1'b1;

  // Presents a command and returns once it is accepted (just after the edge)
  task automatic send(input logic w, input logic [31:0] a, input logic [7:0] d,
                      input rsp_t e, output int acc_at);
    bit got;
    int budget;
    got = 1'b0;
    budget = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!got && budget < 64) begin
      @(negedge pclk);
      got = cmd_ready;
      @(posedge pclk);
      #1;
      budget++;
    end
    if (!got) chk("cmd_accept_bound", 32'd0, 32'd1);
    else exp_q.push_back(e);
    acc_at = cyc;
  endtask

  task automatic wait_rsp(input int start);
    int budget;
    budget = 0;
    while (rsp_count == start && budget < 64) begin
      @(posedge pclk);
      budget++;
    end
    #1;
    chk("rsp_wait_bound", 32'(rsp_count > start), 32'd1);
  endtask

  initial begin
    int c1, c2, n, base, budget;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h3C;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prst = 1'b1;
    #1 prst = 1'b0;
    #2;
    // Reset values before any clock edge
    chk("rst_psel_penable", {30'd0, psel, penable}, 32'd0);
    chk("rst_rsp_flags", {29'd0, rsp_valid, rsp_slverr, rsp_timeout}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_data", {16'd0, pwdata, rsp_rdata}, 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge pclk);
    prst = 1'b1;

    // Zero-wait write; pready tied high must be ignored while idle
    force_rdy = 1'b1;
    repeat (3) @(negedge pclk);
    chk("idle_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge pclk); #1;
    send(1'b1, 32'h0000_0004, 8'hA5, mk(8'h00, 1'b0, 1'b0), c1);
    cmd_valid = 1'b0;
    chk("wr_setup_psel", {30'd0, psel, penable}, 32'd2);
    chk("wr_setup_ready", 32'(cmd_ready), 32'd0);
    @(posedge pclk); #1;
    chk("wr_access_penable", {30'd0, psel, penable}, 32'd3);
    chk("wr_paddr", paddr, 32'h4);
    chk("wr_pwdata", 32'(pwdata), 32'hA5);
    chk("wr_pwrite", 32'(pwrite), 32'd1);
    @(posedge pclk); #1;
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_psel_drop", 32'(psel), 32'd0);
    force_rdy = 1'b0;
    @(posedge pclk); #1;

    // Read with three wait states
    ws = 3;
    base = rsp_count;
    send(1'b0, 32'h0000_0010, 8'h00, mk(8'h3C, 1'b0, 1'b0), c1);
    cmd_valid = 1'b0;
    n = 0; budget = 0;
    while (budget < 40) begin
      @(negedge pclk);
      if (penable) n++;
      if (rsp_valid) break;
      budget++;
    end
    chk("rd_penable_cycles", n, 32'd4);
    repeat (4) @(negedge pclk);
    chk("rd_rsp_once", rsp_count - base, 32'd1);
    ws = 0;
    @(posedge pclk); #1;

    // Back-to-back write then read of the same location
    send(1'b1, 32'h0000_0008, 8'h11, mk(8'h00, 1'b0, 1'b0), c1);
    psel_dropped = 1'b0;
    psel_watch = 1'b1;
    send(1'b0, 32'h0000_0008, 8'h00, mk(8'h11, 1'b0, 1'b0), c2);
    cmd_valid = 1'b0;
    @(posedge pclk); #1;
    psel_watch = 1'b0;
    chk("b2b_period", c2 - c1, 32'd2);
    chk("b2b_psel_held", 32'(psel_dropped), 32'd0);
    base = rsp_count;
    wait_rsp(base - 1);

    // Slave error, then a normal command
    base = rsp_count;
    send(1'b1, 32'h0000_00FF, 8'h5A, mk(8'h00, 1'b1, 1'b0), c1);
    cmd_valid = 1'b0;
    wait_rsp(base);
    base = rsp_count;
    send(1'b0, 32'h0000_0008, 8'h00, mk(8'h11, 1'b0, 1'b0), c1);
    cmd_valid = 1'b0;
    wait_rsp(base);
    repeat (3) @(negedge pclk);
    chk("rsp_rdata_held", 32'(rsp_rdata), 32'h11);
    chk("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
    @(posedge pclk); #1;

    // Timeout on a hung slave
    hang = 1'b1;
    send(1'b0, 32'h0000_0020, 8'h00, mk(8'h00, 1'b1, 1'b1), c1);
    cmd_valid = 1'b0;
    n = 0; budget = 0;
    while (budget < 64) begin
      @(negedge pclk);
      if (psel && penable) n++;
      if (rsp_valid) break;
      budget++;
    end
    chk("to_access_cycles", n, 32'd16);
    chk("to_psel_low", 32'(psel), 32'd0);
    @(posedge pclk); #1;

    // Asynchronous reset during a wait state
    send(1'b0, 32'h0000_0010, 8'h00, mk(8'h3C, 1'b0, 1'b0), c1);
    cmd_valid = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #3;
    prst = 1'b0;
    #1;
    chk("arst_bus", {29'd0, psel, penable, rsp_valid}, 32'd0);
    chk("arst_paddr", paddr, 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_pending", exp_q.size(), 32'd1);
    exp_q.delete();
    hang = 1'b0;
    @(negedge pclk);
    prst = 1'b1;
    base = rsp_count;
    repeat (5) @(negedge pclk);
    chk("arst_no_stale_rsp", rsp_count - base, 32'd0);
    chk("arst_idle_ready", 32'(cmd_ready), 32'd1);
    @(posedge pclk); #1;
    send(1'b0, 32'h0000_0010, 8'h00, mk(8'h3C, 1'b0, 1'b0), c1);
    cmd_valid = 1'b0;
    wait_rsp(base);
    repeat (3) @(negedge pclk);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
